// File: rtl/capi_pkg.sv
// rtl/capi_pkg.sv - shared page/cacheline geometry and segment-length helper
package capi_pkg;

  localparam int CL_LG  = 7;
  localparam int PG_LG  = 12;
  localparam int CWIDTH = PG_LG - CL_LG;
  // Wide enough for a request length and for a full page (2^PG_LG).
  localparam int SEG_W  = (16 > PG_LG + 1) ? 16 : PG_LG + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [SEG_W-1:0] seg_len(input logic [SEG_W-1:0] rem,
                                               input logic [PG_LG-1:0] off);
    logic [SEG_W-1:0] room;
    room = SEG_W'(1 << PG_LG) - SEG_W'(off);
    return (rem < room) ? rem : room;
  endfunction

endpackage

// File: rtl/base_alatch.sv
// rtl/base_alatch.sv - single-entry valid/ready output register
module base_alatch #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [width-1:0] d_i,
  input  logic             rdy_i,
  output logic             free_o,
  output logic             v_o,
  output logic [width-1:0] q_o
);

  logic             v_q;
  logic [width-1:0] q_q;

  // The slot may be refilled in the same cycle its current entry is taken.
  assign free_o = ~v_q | rdy_i;
  assign v_o    = v_q;
  assign q_o    = q_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v_q <= 1'b0;
      q_q <= '0;
    end else if (free_o) begin
      v_q <= load_i;
      if (load_i) begin
        q_q <= d_i;
      end
    end
  end

endmodule

// File: rtl/capi_xfer_split.sv
// rtl/capi_xfer_split.sv - splits a byte request into per-page cacheline segments
module capi_xfer_split
  import capi_pkg::*;
#(
  parameter int ea_width  = 64,
  parameter int len_width = 16,
  parameter int tag_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_v,
  input  logic [ea_width-1:0]  req_ea,
  input  logic [len_width-1:0] req_len,
  input  logic [tag_width-1:0] req_tag,
  output logic                 req_acc,
  output logic                 o_v,
  output logic [ea_width-1:0]  o_base,
  output logic [CWIDTH-1:0]    o_cstart,
  output logic [CWIDTH-1:0]    o_cend,
  output logic [CL_LG-1:0]     o_sbyte,
  output logic [CL_LG-1:0]     o_ebyte,
  output logic [tag_width-1:0] o_tag,
  output logic                 o_first,
  output logic                 o_last,
  input  logic                 o_r
);

  localparam int OW = ea_width + 2 * CWIDTH + 2 * CL_LG + tag_width + 2;

  state_t               state_q, state_d;
  logic [ea_width-1:0]  cur_ea_q, cur_ea_d;
  logic [SEG_W-1:0]     rem_q, rem_d;
  logic [tag_width-1:0] tag_q, tag_d;
  logic                 first_q, first_d;

  logic [SEG_W-1:0]     seg;
  logic                 seg_last;
  logic [PG_LG-1:0]     end_off;
  logic                 slot_free;
  logic                 issue;
  logic                 load_new;
  logic [OW-1:0]        seg_word;
  logic [OW-1:0]        out_word;

  assign seg      = seg_len(rem_q, cur_ea_q[PG_LG-1:0]);
  assign seg_last = (seg == rem_q);
  // Only the in-page part of the end address matters; modulo page arithmetic suffices.
  assign end_off  = cur_ea_q[PG_LG-1:0] + seg[PG_LG-1:0] - PG_LG'(1);
  assign load_new = req_v & req_acc & (req_len != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_new) state_d = ST_BUSY;
      ST_BUSY: if (issue && seg_last) state_d = load_new ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_acc = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: req_acc = 1'b1;
      ST_BUSY: begin
        issue   = slot_free;
        req_acc = slot_free & seg_last;
      end
      default: req_acc = 1'b0;
    endcase
  end

  always_comb begin
    cur_ea_d = cur_ea_q;
    rem_d    = rem_q;
    tag_d    = tag_q;
    first_d  = first_q;
    if (load_new) begin
      cur_ea_d = req_ea;
      rem_d    = SEG_W'(req_len);
      tag_d    = req_tag;
      first_d  = 1'b1;
    end else if (issue) begin
      cur_ea_d = cur_ea_q + ea_width'(seg);
      rem_d    = rem_q - seg;
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    cur_ea_q <= cur_ea_d;
    rem_q    <= rem_d;
    tag_q    <= tag_d;
    first_q  <= first_d;
  end

  assign seg_word = {cur_ea_q[ea_width-1:PG_LG], {PG_LG{1'b0}},
                     cur_ea_q[PG_LG-1:CL_LG], end_off[PG_LG-1:CL_LG],
                     cur_ea_q[CL_LG-1:0], end_off[CL_LG-1:0],
                     tag_q, first_q, seg_last};

  base_alatch #(.width(OW)) u_out (
    .clk    (clk),
    .resetn (reset),
    .load_i (issue),
    .d_i    (seg_word),
    .rdy_i  (o_r),
    .free_o (slot_free),
    .v_o    (o_v),
    .q_o    (out_word)
  );

  assign {o_base, o_cstart, o_cend, o_sbyte, o_ebyte, o_tag, o_first, o_last} = out_word;

endmodule

// File: tb/tb_capi_xfer_split.sv
// tb/tb_capi_xfer_split.sv - scoreboard bench for capi_xfer_split
module tb_capi_xfer_split;

  typedef struct packed {
    logic [63:0] base;
    logic [4:0]  cs;
    logic [4:0]  ce;
    logic [6:0]  sb;
    logic [6:0]  eb;
    logic [7:0]  tag;
    logic        first;
    logic        last;
  } seg_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v;
  logic [63:0] req_ea;
  logic [15:0] req_len;
  logic [7:0]  req_tag;
  logic        req_acc;
  logic        o_v;
  logic [63:0] o_base;
  logic [4:0]  o_cstart, o_cend;
  logic [6:0]  o_sbyte, o_ebyte;
  logic [7:0]  o_tag;
  logic        o_first, o_last;
  logic        o_r;

  seg_t exp_q[$];
  int   pop_cyc[$];
  seg_t act_seg, exp_seg, snap;
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  capi_xfer_split dut (
    .clk(clk), .reset(reset), .req_v(req_v), .req_ea(req_ea), .req_len(req_len),
    .req_tag(req_tag), .req_acc(req_acc), .o_v(o_v), .o_base(o_base),
    .o_cstart(o_cstart), .o_cend(o_cend), .o_sbyte(o_sbyte), .o_ebyte(o_ebyte),
    .o_tag(o_tag), .o_first(o_first), .o_last(o_last), .o_r(o_r)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && o_v && o_r) begin
      act_seg = {o_base, o_cstart, o_cend, o_sbyte, o_ebyte, o_tag, o_first, o_last};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL seg_unexpected: got base=%h cs=%0d ce=%0d sb=%h eb=%h tag=%h f=%b l=%b, want none",
                 act_seg.base, act_seg.cs, act_seg.ce, act_seg.sb, act_seg.eb, act_seg.tag,
                 act_seg.first, act_seg.last);
      end else begin
        exp_seg = exp_q.pop_front();
        if (act_seg !== exp_seg) begin
          errors++;
          $display("FAIL seg%0d: got base=%h cs=%0d ce=%0d sb=%h eb=%h tag=%h f=%b l=%b, want base=%h cs=%0d ce=%0d sb=%h eb=%h tag=%h f=%b l=%b",
                   popped, act_seg.base, act_seg.cs, act_seg.ce, act_seg.sb, act_seg.eb,
                   act_seg.tag, act_seg.first, act_seg.last, exp_seg.base, exp_seg.cs,
                   exp_seg.ce, exp_seg.sb, exp_seg.eb, exp_seg.tag, exp_seg.first, exp_seg.last);
        end
      end
      pop_cyc.push_back(cyc);
      popped++;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] base, input logic [4:0] cs, input logic [4:0] ce,
                      input logic [6:0] sb, input logic [6:0] eb, input logic [7:0] tag,
                      input logic first, input logic last);
    exp_q.push_back({base, cs, ce, sb, eb, tag, first, last});
  endtask

  task automatic send(input logic [63:0] ea, input logic [15:0] len, input logic [7:0] tag);
    bit done = 0;
    req_v = 1'b1; req_ea = ea; req_len = len; req_tag = tag;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_acc) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL req_acc_timeout: got no accept, want accept for ea=%h", ea);
    end
    @(posedge clk); #1;
    req_v = 1'b0;
  endtask

  task automatic wait_popped(input int target);
    for (int i = 0; i < 200 && popped < target; i++) begin
      @(posedge clk); #1;
    end
    check("wait_popped", 128'(popped), 128'(target));
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int p0;
    int n0;
    reset = 1'b0; req_v = 1'b0; req_ea = '0; req_len = '0; req_tag = '0; o_r = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_o_v", 128'(o_v), 128'd0);
    check("reset_o_first", 128'(o_first), 128'd0);
    check("reset_o_last", 128'(o_last), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_req_acc", 128'(req_acc), 128'd1);
    @(posedge clk); #1;

    // one full page
    push(64'h1000, 5'd0, 5'd31, 7'h00, 7'h7F, 8'h05, 1'b1, 1'b1);
    send(64'h1000, 16'h1000, 8'h05);
    drain();

    // straddles a page boundary
    push(64'h0000, 5'd31, 5'd31, 7'h70, 7'h7F, 8'h22, 1'b1, 1'b0);
    push(64'h1000, 5'd0, 5'd0, 7'h00, 7'h0F, 8'h22, 1'b0, 1'b1);
    send(64'h0FF0, 16'h0020, 8'h22);
    drain();

    // four segments with a 5-cycle downstream stall on seg2
    push(64'h0000, 5'd0, 5'd31, 7'h10, 7'h7F, 8'h33, 1'b1, 1'b0);
    push(64'h1000, 5'd0, 5'd31, 7'h00, 7'h7F, 8'h33, 1'b0, 1'b0);
    push(64'h2000, 5'd0, 5'd31, 7'h00, 7'h7F, 8'h33, 1'b0, 1'b0);
    push(64'h3000, 5'd0, 5'd0, 7'h00, 7'h0F, 8'h33, 1'b0, 1'b1);
    send(64'h0010, 16'h3000, 8'h33);
    p0 = popped;
    wait_popped(p0 + 1);
    o_r = 1'b0;
    snap = {o_base, o_cstart, o_cend, o_sbyte, o_ebyte, o_tag, o_first, o_last};
    check("stall_seg2_base", 128'(snap.base), 128'h1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_o_v", 128'(o_v), 128'd1);
      check("stall_hold", 128'({o_base, o_cstart, o_cend, o_sbyte, o_ebyte, o_tag, o_first, o_last}),
            128'(snap));
    end
    @(posedge clk); #1;
    o_r = 1'b1;
    drain();

    // null request then a single byte
    send(64'h2000, 16'h0000, 8'h44);
    push(64'h0000, 5'd1, 5'd1, 7'h00, 7'h00, 8'h45, 1'b1, 1'b1);
    send(64'h0080, 16'h0001, 8'h45);
    drain();

    // wraps across the top of the address space
    push(64'hFFFF_FFFF_FFFF_F000, 5'd31, 5'd31, 7'h00, 7'h7F, 8'h55, 1'b1, 1'b0);
    push(64'h0000, 5'd0, 5'd0, 7'h00, 7'h7F, 8'h55, 1'b0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FF80, 16'h0100, 8'h55);
    drain();

    // reset mid-request discards the remainder
    push(64'h0000, 5'd0, 5'd31, 7'h10, 7'h7F, 8'h66, 1'b1, 1'b0);
    send(64'h0010, 16'h3000, 8'h66);
    p0 = popped;
    wait_popped(p0 + 1);
    o_r = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_o_v", 128'(o_v), 128'd0);
    check("midreset_o_first", 128'(o_first), 128'd0);
    check("midreset_o_last", 128'(o_last), 128'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_req_acc", 128'(req_acc), 128'd1);
    @(posedge clk); #1;
    o_r = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", 128'(o_v), 128'd0);
    @(posedge clk); #1;

    // back-to-back requests, no idle cycle between them
    push(64'h0000, 5'd0, 5'd0, 7'h00, 7'h7F, 8'h77, 1'b1, 1'b1);
    push(64'h0000, 5'd2, 5'd2, 7'h00, 7'h7F, 8'h78, 1'b1, 1'b1);
    n0 = pop_cyc.size();
    send(64'h0000, 16'h0080, 8'h77);
    send(64'h0100, 16'h0080, 8'h78);
    drain();
    if (pop_cyc.size() >= n0 + 2) begin
      check("no_bubble", 128'(pop_cyc[n0+1] - pop_cyc[n0]), 128'd1);
    end else begin
      checks++; errors++;
      $display("FAIL no_bubble: got %0d segments, want 2", pop_cyc.size() - n0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
